// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Brief    : FIFO-buffered launcher for a UART transmitter. It issues one
//            tx_start per frame and waits for tx_done_tick before the next.
//            Optional macro UART_TX_FEEDER_CTS_EN adds a synchronised cts gate.
// Revision : 1.0
// ============================================================================
module uart_tx_feeder #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_data,
  input  logic              tx_done_tick,
`ifdef UART_TX_FEEDER_CTS_EN
  input  logic              cts,
`endif
  output logic              busy
);

  localparam int             c_DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [DBIT-1:0]   r_mem [c_DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;
  logic [DBIT-1:0]   r_tx_data;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_accept;
  logic              w_pop;
  logic              w_tx_start;
  logic              w_busy;
  logic              w_cts_ok;

  // Extra pointer MSB separates "wrapped once" (full) from "caught up" (empty).
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // A same-cycle pop never frees a slot for a write: acceptance uses registered full.
  assign w_wr_accept = wr && !w_full;

`ifdef UART_TX_FEEDER_CTS_EN
  logic r_cts_meta;
  logic r_cts_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cts_meta <= 1'b0;
      r_cts_sync <= 1'b0;
    end else begin
      r_cts_meta <= cts;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = r_cts_sync;
`else
  assign w_cts_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_overflow <= wr && w_full;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
        r_tx_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // tx_done_tick is only honoured in BUSY, so one done can release at most one launch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_start   = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (!w_empty && w_cts_ok) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_start   = 1'b1;
        w_state_next = S_BUSY;
      end
      S_BUSY: begin
        if (tx_done_tick) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign full          = w_full;
  assign empty         = w_empty;
  assign level         = r_wr_ptr - r_rd_ptr;
  assign overflow_tick = r_overflow;
  assign tx_start      = w_tx_start;
  assign tx_data       = r_tx_data;
  assign busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Brief    : Scoreboard bench for uart_tx_feeder; a monitor pops expected
//            words on every tx_start while directed stimulus drives the FIFO.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr = 1'b0;
  logic [DBIT-1:0]   w_data = '0;
  logic              tx_done_tick = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow_tick;
  logic              tx_start;
  logic [DBIT-1:0]   tx_data;
  logic              busy;
`ifdef UART_TX_FEEDER_CTS_EN
  logic              cts = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts_seen = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int acked = 0;
  int peak = 0;
  bit gap_check = 1'b0;
  bit prev_start = 1'b0;
  logic [DBIT-1:0] expq [$];

  uart_tx_feeder #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr            (wr),
    .w_data        (w_data),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow_tick (overflow_tick),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_done_tick  (tx_done_tick),
`ifdef UART_TX_FEEDER_CTS_EN
    .cts           (cts),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every launch must match the oldest outstanding word.
  always @(negedge clk) begin
    logic [DBIT-1:0] e;
    if (reset && tx_start) begin
      starts_seen++;
      start_cyc = cyc;
      check("start_single_cycle", {31'd0, prev_start}, 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got tx_data %0h expected no launch", tx_data);
      end else begin
        e = expq.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e});
      end
      if (gap_check && done_cyc >= 0) check("done_to_start_gap", cyc - done_cyc, 32'd2);
    end
    prev_start = tx_start;
    if (int'(level) > peak) peak = int'(level);
  end

  task automatic push(input logic [DBIT-1:0] d, input bit accepted);
    @(negedge clk);
    wr = 1'b1;
    w_data = d;
    if (accepted) expq.push_back(d);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done_tick = 1'b1;
    done_cyc = cyc;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic respond(input int delay);
    int t = 0;
    while (starts_seen <= acked && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (starts_seen <= acked) begin
      checks++;
      errors++;
      $display("FAIL respond_timeout: got %0d launches expected %0d", starts_seen, acked + 1);
      return;
    end
    acked++;
    while (cyc < start_cyc + delay) @(negedge clk);
    pulse_done();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_full"},     {31'd0, full}, 32'd0);
    check({tag, "_empty"},    {31'd0, empty}, 32'd1);
    check({tag, "_level"},    {27'd0, level}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow_tick}, 32'd0);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int s0;
    int c0;
    int t;

    // Reset and single word
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    push(8'hA5, 1'b1);
    @(negedge clk); wr = 1'b0;
    check("single_empty", {31'd0, empty}, 32'd0);
    check("single_level", {27'd0, level}, 32'd1);
    check("single_no_start_yet", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("single_start", {31'd0, tx_start}, 32'd1);
    check("single_level_after_pop", {27'd0, level}, 32'd0);
    check("single_busy_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_start_dropped", {31'd0, tx_start}, 32'd0);
    check("single_busy_wait", {31'd0, busy}, 32'd1);
    respond(5);
    check("single_busy_released", {31'd0, busy}, 32'd0);

    // Done in IDLE must be ignored
    s0 = starts_seen;
    pulse_done();
    repeat (3) @(negedge clk);
    check("idle_done_no_launch", starts_seen, s0);
    check("idle_done_busy", {31'd0, busy}, 32'd0);

    // Burst of five with 20-cycle transmitter
    peak = 0;
    done_cyc = -1;
    gap_check = 1'b1;
    for (int i = 1; i <= 5; i++) push(i[7:0], 1'b1);
    @(negedge clk); wr = 1'b0;
    check("burst_level_after_pushes", {27'd0, level}, 32'd4);
    repeat (5) respond(20);
    gap_check = 1'b0;
    check("burst_peak_level", peak, 32'd4);
    check("burst_empty", {31'd0, empty}, 32'd1);

    // Fill to full with transmitter stalled; 0x21 is dropped
    for (int i = 0; i <= 16; i++) push(8'h10 + i[7:0], 1'b1);
    @(negedge clk);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_level16", {27'd0, level}, 32'd16);
    check("fill_no_overflow_yet", {31'd0, overflow_tick}, 32'd0);
    w_data = 8'h21;
    @(negedge clk); wr = 1'b0;
    check("overflow_tick", {31'd0, overflow_tick}, 32'd1);
    check("overflow_level", {27'd0, level}, 32'd16);
    @(negedge clk);
    check("overflow_one_cycle", {31'd0, overflow_tick}, 32'd0);

    // Rejected push in the same cycle as the pop that follows done
    @(negedge clk);
    tx_done_tick = 1'b1;
    done_cyc = cyc;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("simul_full_before", {31'd0, full}, 32'd1);
    wr = 1'b1;
    w_data = 8'h99;
    acked++;
    @(negedge clk); wr = 1'b0;
    check("simul_level15", {27'd0, level}, 32'd15);
    check("simul_overflow", {31'd0, overflow_tick}, 32'd1);
    check("simul_not_full", {31'd0, full}, 32'd0);
    check("simul_launch", {31'd0, tx_start}, 32'd1);
    repeat (16) respond(3);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) push(8'h30 + i[7:0], 1'b1);
    @(negedge clk); wr = 1'b0;
    check("midreset_level3", {27'd0, level}, 32'd3);
    check("midreset_busy", {31'd0, busy}, 32'd1);
    check("midreset_one_launched", expq.size(), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy_cleared", {31'd0, busy}, 32'd0);
    check("midreset_empty", {31'd0, empty}, 32'd1);
    check("midreset_tx_start", {31'd0, tx_start}, 32'd0);
    check("midreset_level0", {27'd0, level}, 32'd0);
    expq.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    acked = starts_seen;
    s0 = starts_seen;
    repeat (10) @(negedge clk);
    check("midreset_no_relaunch", starts_seen, s0);

`ifdef UART_TX_FEEDER_CTS_EN
    // CTS gating
    cts = 1'b0;
    repeat (2) @(negedge clk);
    push(8'h40, 1'b1);
    push(8'h41, 1'b1);
    @(negedge clk); wr = 1'b0;
    s0 = starts_seen;
    repeat (6) @(negedge clk);
    check("cts_low_no_launch", starts_seen, s0);
    check("cts_low_level2", {27'd0, level}, 32'd2);
    @(negedge clk);
    cts = 1'b1;
    c0 = cyc;
    t = 0;
    while (starts_seen == s0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cts_rise_launch", starts_seen, s0 + 1);
    check("cts_rise_latency", start_cyc - c0, 32'd3);
    cts = 1'b0;
    respond(5);
    check("cts_frame_completed", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("cts_low_holds_next", starts_seen, s0 + 1);
    check("cts_low_level1", {27'd0, level}, 32'd1);
    cts = 1'b1;
    respond(5);
    check("cts_drain_empty", {31'd0, empty}, 32'd1);
`else
    c0 = 0;
    t = 0;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side buffer and sequencer that sits directly upstream of the UART transmitter. Host logic pushes bytes into an internal FIFO at any rate. The feeder pops one word at a time, presents it with a one-cycle `tx_start`, and waits for the transmitter's `tx_done_tick` before launching the next frame. It decouples bursty producers from the serial line and optionally honours a CTS flow-control input.

## Interface
- `DBIT`, 8, data word width; matches the transmitter's storage width.
- `ADDR_W`, 4, FIFO address width; depth = 2^ADDR_W words (16).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `wr`  in  1  push request; `w_data` is captured when `wr`=1 and `full`=0.
- `w_data`  in  DBIT  word to enqueue.
- `full`  out  1  FIFO holds 2^ADDR_W words.
- `empty`  out  1  FIFO holds 0 words.
- `level`  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.
- `overflow_tick`  out  1  one-cycle pulse when `wr`=1 while `full`=1; the word is dropped.
- `tx_start`  out  1  one-cycle launch strobe to the transmitter.
- `tx_data`  out  DBIT  word for the transmitter; valid while `tx_start`=1, held until the next pop.
- `tx_done_tick`  in  1  one-cycle completion pulse from the transmitter (end of stop bit).
- `busy`  out  1  high from launch until `tx_done_tick` is accepted.
- `cts`  in  1  present only with `UART_TX_FEEDER_CTS_EN`; active-high clear-to-send.

## Operation
- FIFO: circular buffer with ADDR_W+1-bit read/write pointers. The MSB distinguishes full from empty. Pointers wrap modulo 2^(ADDR_W+1).
- `full`, `empty` and `level` are derived from the registered pointers. A write is accepted only when `full`=0 at that edge. A pop in the same cycle does not make room for a write while `full`=1.
- Simultaneous accepted write and pop: pointers both advance and `level` is unchanged.
- FSM states:
  - IDLE: if `empty`=0 (and clear-to-send), pop the head word into the `tx_data` register and go to START. Otherwise stay.
  - START: `tx_start`=1 for exactly this cycle; go to BUSY unconditionally.
  - BUSY: wait for `tx_done_tick`=1, then go to IDLE.
- `busy`=1 in START and BUSY.
- `tx_done_tick` in IDLE or START is ignored; it creates no state change and no pop.
- The FSM never launches more than one frame per `tx_done_tick`.
- Reset mid-frame: FSM goes to IDLE and the FIFO is emptied (pointers 0). The transmitter must be reset by the same event; no frame is resumed.

## Timing
- Reset values: `full`=0, `empty`=1, `level`=0, `overflow_tick`=0, `tx_start`=0, `tx_data`=0, `busy`=0. All state is cleared asynchronously on `reset`=0.
- Write at edge k into an empty FIFO with the FSM in IDLE:
  - `empty`=0 and `level`=1 after edge k.
  - Pop at edge k+1.
  - `tx_start`=1 with valid `tx_data` during the cycle after edge k+1; `level`=0 from then.
  - Write-to-`tx_start` latency is 2 cycles.
- `tx_done_tick` sampled at edge m: FSM is in IDLE after m. If the FIFO is non-empty, `tx_start` is asserted after edge m+1. Gap between done and next start is 2 cycles, which satisfies the transmitter's return-to-idle cycle.
- `overflow_tick` is registered: it is high for the cycle after the rejected write.

## Configuration
- `UART_TX_FEEDER_CTS_EN` defined:
  - `cts` port exists.
  - The IDLE→START transition additionally requires `cts`=1, sampled at the pop edge.
  - `cts` is double-flop synchronised inside the block; add 2 cycles of latency on `cts` edges.
  - Deasserting `cts` never aborts START or BUSY; the current frame completes.
- Not defined: no `cts` port; the IDLE→START transition depends only on `empty`.

## Test plan
- Reset values and single word:
  - Stimulus: reset low for 3 cycles, release; check all reset values. Push 0xA5 at edge k.
  - Required: `tx_start`=1 for exactly one cycle after k+1 with `tx_data`=0xA5; `busy`=1 until 1 cycle after `tx_done_tick`.
- Burst and back-to-back launch:
  - Stimulus: push 0x01..0x05 on consecutive cycles; respond with `tx_done_tick` 20 cycles after each `tx_start`.
  - Required: five launches in order 0x01..0x05. Each `tx_start` follows the prior `tx_done_tick` by 2 cycles. `level` peaks at 4.
- Full and overflow:
  - Stimulus: hold `tx_done_tick`=0 and push 18 words 0x10..0x21.
  - Required: first word launched; `full`=1 once 16 are queued; `overflow_tick` pulses for the rejected pushes; later drain yields 0x10..0x20 only.
- Simultaneous push/pop at full:
  - Stimulus: push while `full`=1 in the same cycle as a pop.
  - Required: word dropped, `overflow_tick`=1, `level` drops to 15.
- Reset mid-frame:
  - Stimulus: with 3 words queued and the FSM in BUSY, assert `reset`=0 asynchronously for 1 cycle.
  - Required: `busy`=0, `empty`=1 and `tx_start`=0 immediately; no launch after release.
- CTS (macro defined):
  - Stimulus: `cts`=0 with 2 words queued.
  - Required: no `tx_start`. Raising `cts` gives the first `tx_start` 3 cycles after the `cts` edge. Dropping `cts` during BUSY still lets that frame finish; the next launch waits for `cts`=1.
